// File: rtl/branch_resolve.sv
// Branch resolution: queues predicted-taken targets from fetch, checks them against
// execute outcomes, and issues a one-cycle PC correction on a mispredict.
module branch_resolve #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clock_in,
   input  logic                     reset_in,
   input  logic                     pred_push_in,
   input  logic [XLEN-1:0]          pred_target_in,
   output logic                     pred_ready_out,
   input  logic                     res_valid_in,
   input  logic                     res_pred_in,
   input  logic                     res_taken_in,
   input  logic [XLEN-1:0]          res_pc_in,
   input  logic [XLEN-1:0]          res_target_in,
   output logic                     correction_en_out,
   output logic [XLEN-1:0]          correction_addr_out,
   output logic [15:0]              mispredict_count_out,
   output logic [$clog2(DEPTH):0]   queue_count_out,
   output logic                     error_out
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic {RUN, CORRECT} state_t;

   state_t            state;
   logic [XLEN-1:0]   mem [DEPTH];
   logic [AW-1:0]     rd_ptr, wr_ptr;
   logic [AW:0]       count;

   logic              full, empty, resolve, mispredict, pop, push_acc, empty_pop;
   logic [XLEN-1:0]   head, fix_addr;

   assign full           = (count == (AW+1)'(DEPTH));
   assign empty          = (count == '0);
   assign pred_ready_out = !full;
   assign head           = mem[rd_ptr];
   assign resolve        = (state == RUN) && res_valid_in;
   assign fix_addr       = res_taken_in ? res_target_in : res_pc_in + XLEN'(4);

   always_comb begin
      mispredict = 1'b0;
      empty_pop  = 1'b0;
      if (resolve && res_pred_in) begin
         empty_pop  = empty;
         mispredict = empty || !(res_taken_in && (res_target_in == head));
      end else if (resolve && res_taken_in) begin
         mispredict = 1'b1;
      end
   end

   assign pop      = resolve && res_pred_in && !empty;
   // A push landing on the mispredict edge is wrong-path and is discarded by the flush.
   assign push_acc = pred_push_in && !full && !mispredict;

   always_ff @(posedge clock_in) begin
      if (push_acc) mem[wr_ptr] <= pred_target_in;
   end

   always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) begin
         state                <= RUN;
         rd_ptr               <= '0;
         wr_ptr               <= '0;
         count                <= '0;
         correction_en_out    <= 1'b0;
         correction_addr_out  <= '0;
         mispredict_count_out <= '0;
         error_out            <= 1'b0;
      end else begin
         if ((pred_push_in && full) || empty_pop) error_out <= 1'b1;
         if (mispredict) begin
            state               <= CORRECT;
            correction_en_out   <= 1'b1;
            correction_addr_out <= fix_addr;
            rd_ptr              <= '0;
            wr_ptr              <= '0;
            count               <= '0;
            if (mispredict_count_out != 16'hFFFF)
               mispredict_count_out <= mispredict_count_out + 16'd1;
         end else begin
            state             <= RUN;
            correction_en_out <= 1'b0;
            if (push_acc) wr_ptr <= wr_ptr + AW'(1);
            if (pop)      rd_ptr <= rd_ptr + AW'(1);
            if (push_acc && !pop)      count <= count + (AW+1)'(1);
            else if (pop && !push_acc) count <= count - (AW+1)'(1);
         end
      end
   end

   assign queue_count_out = count;

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_branch_resolve;

   localparam int XLEN  = 32;
   localparam int DEPTH = 4;

   logic              clk = 0;
   logic              rst;
   logic              push;
   logic [XLEN-1:0]   ptgt;
   logic              ready;
   logic              valid, rpred, taken;
   logic [XLEN-1:0]   pc, rtgt;
   logic              en;
   logic [XLEN-1:0]   addr;
   logic [15:0]       mcnt;
   logic [$clog2(DEPTH):0] qcnt;
   logic              err;

   int n_chk = 0;
   int n_err = 0;

   // reference model state
   logic [XLEN-1:0] q[$];
   bit              m_corr, m_en, m_err;
   logic [XLEN-1:0] m_addr;
   int              m_cnt;

   always #5 clk = ~clk;

   branch_resolve #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
      .clock_in(clk), .reset_in(rst),
      .pred_push_in(push), .pred_target_in(ptgt), .pred_ready_out(ready),
      .res_valid_in(valid), .res_pred_in(rpred), .res_taken_in(taken),
      .res_pc_in(pc), .res_target_in(rtgt),
      .correction_en_out(en), .correction_addr_out(addr),
      .mispredict_count_out(mcnt), .queue_count_out(qcnt), .error_out(err)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".en"},    64'(en),    64'(m_en));
      chk({tag, ".addr"},  64'(addr),  64'(m_addr));
      chk({tag, ".mcnt"},  64'(mcnt),  64'(m_cnt));
      chk({tag, ".qcnt"},  64'(qcnt),  64'(q.size()));
      chk({tag, ".err"},   64'(err),   64'(m_err));
      chk({tag, ".ready"}, 64'(ready), 64'(q.size() < DEPTH));
   endtask

   task automatic model_reset();
      q.delete();
      m_corr = 0; m_en = 0; m_err = 0; m_addr = '0; m_cnt = 0;
   endtask

   // Advance one clock: model consumes the inputs seen before the edge, DUT is
   // sampled 1 time unit after the edge.
   task automatic step(input string tag, input bit do_chk = 1);
      bit full, mis;
      logic [XLEN-1:0] fa, h;
      full = (q.size() == DEPTH);
      mis  = 0;
      fa   = taken ? rtgt : pc + 32'd4;
      if (push && full) m_err = 1;
      if (m_corr) begin
         m_corr = 0; m_en = 0;
         if (push && !full) q.push_back(ptgt);
      end else begin
         if (valid && rpred) begin
            if (q.size() == 0) begin
               m_err = 1; mis = 1;
            end else begin
               h = q.pop_front();
               if (!(taken && rtgt == h)) mis = 1;
            end
         end else if (valid && taken) begin
            mis = 1;
         end
         if (mis) begin
            q.delete();
            m_en = 1; m_addr = fa; m_corr = 1;
            if (m_cnt < 65535) m_cnt++;
         end else begin
            m_en = 0;
            if (push && !full) q.push_back(ptgt);
         end
      end
      @(posedge clk); #1;
      if (do_chk) chk_all(tag);
   endtask

   task automatic idle();
      push = 0; valid = 0; rpred = 0; taken = 0;
   endtask

   task automatic do_reset();
      rst = 1; #2;
      model_reset();
      chk("rst.en",    64'(en),    64'd0);
      chk("rst.addr",  64'(addr),  64'd0);
      chk("rst.mcnt",  64'(mcnt),  64'd0);
      chk("rst.qcnt",  64'(qcnt),  64'd0);
      chk("rst.err",   64'(err),   64'd0);
      chk("rst.ready", 64'(ready), 64'd1);
      @(posedge clk); #1;
      rst = 0;
   endtask

   initial begin
      rst = 1; idle(); ptgt = '0; pc = '0; rtgt = '0;
      #1;
      do_reset();

      // correct prediction
      push = 1; ptgt = 32'h100; step("p100");
      chk("c1.qcnt", 64'(qcnt), 64'd1);
      push = 0; valid = 1; rpred = 1; taken = 1; rtgt = 32'h100; step("hit");
      chk("c1.en",   64'(en),   64'd0);
      chk("c1.mcnt", 64'(mcnt), 64'd0);
      chk("c1.q0",   64'(qcnt), 64'd0);
      idle(); step("c1.idle");

      // predicted taken, actually not taken
      push = 1; ptgt = 32'h100; step("p100b");
      push = 0; valid = 1; rpred = 1; taken = 0; pc = 32'h80; step("nt");
      chk("c2.en",   64'(en),   64'd1);
      chk("c2.addr", 64'(addr), 64'h84);
      chk("c2.mcnt", 64'(mcnt), 64'd1);
      idle(); step("c2.after");
      chk("c2.pulse", 64'(en),  64'd0);
      chk("c2.hold",  64'(addr), 64'h84);

      // unpredicted taken, next-cycle resolve ignored
      valid = 1; rpred = 0; taken = 1; rtgt = 32'h200; step("upt");
      chk("c3.en",   64'(en),   64'd1);
      chk("c3.addr", 64'(addr), 64'h200);
      rtgt = 32'h300; step("c3.ign");
      chk("c3.ign.en",   64'(en),   64'd0);
      chk("c3.ign.addr", 64'(addr), 64'h200);
      chk("c3.ign.mcnt", 64'(mcnt), 64'd2);
      idle(); step("c3.idle");

      // simultaneous push on mispredict edge is flushed
      push = 1; ptgt = 32'h10; step("f1");
      ptgt = 32'h14; step("f2");
      valid = 1; rpred = 0; taken = 1; rtgt = 32'h500; ptgt = 32'h18; step("flush");
      chk("c5.qcnt", 64'(qcnt), 64'd0);
      idle(); step("c5.idle");

      // overflow
      push = 1;
      for (int i = 0; i < DEPTH; i++) begin
         ptgt = 32'h1000 + 32'(i * 4); step("fill");
      end
      chk("c4.ready", 64'(ready), 64'd0);
      ptgt = 32'hDEAD; step("ovf");
      chk("c4.err",  64'(err),  64'd1);
      chk("c4.qcnt", 64'(qcnt), 64'(DEPTH));
      idle(); step("c4.idle");
      // drain in order, all correct
      for (int i = 0; i < DEPTH; i++) begin
         valid = 1; rpred = 1; taken = 1; rtgt = 32'h1000 + 32'(i * 4); step("drain");
      end
      chk("c4.drain.mcnt", 64'(mcnt), 64'd3);
      idle(); step("c4.end");
      do_reset();

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         push  = ($urandom_range(0, 2) != 0);
         ptgt  = 32'h100 + 32'($urandom_range(0, 2) * 4);
         valid = ($urandom_range(0, 2) == 0);
         rpred = $urandom_range(0, 1);
         taken = ($urandom_range(0, 3) != 0);
         rtgt  = 32'h100 + 32'($urandom_range(0, 2) * 4);
         pc    = {$urandom, 2'b00};
         step("rnd");
      end
      idle(); step("rnd.end");

      // saturation: every RUN cycle mispredicts, every CORRECT cycle ignores
      valid = 1; rpred = 0; taken = 1; rtgt = 32'h400;
      for (int i = 0; i < 131080; i++) step("sat", 0);
      chk_all("sat");
      chk("sat.mcnt", 64'(mcnt), 64'hFFFF);
      idle(); step("sat.idle");

      // reset in CORRECT kills the pending pulse
      valid = 1; rpred = 0; taken = 1; rtgt = 32'h600; step("pre.rst");
      chk("rc.en", 64'(en), 64'd1);
      idle();
      do_reset();
      step("rc.nopulse");
      chk("rc.nopulse.en", 64'(en), 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
